fetch_stage: RTL and testbench

- Instruction fetch stage of the MIPS32 pipeline. Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Loads the IF/ID pipeline register and exports the 12-bit {opcode, funct} field that the control unit decodes in ID.
- Supports hazard stalls, with a one-entry skid buffer so no in-flight fetch is lost, and branch/jump redirects that flush younger work.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS32 instruction fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory and loads the IF/ID register, with a one-entry skid for stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [11:0] if_id_ctrl
);

  logic [31:0] pc_reg, pc_next;
  logic        inflight_reg, inflight_next;
  logic [31:0] inflight_pc_reg, inflight_pc_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic        if_id_valid_reg, if_id_valid_next;
  logic [31:0] if_id_instr_reg, if_id_instr_next;
  logic [31:0] if_id_pc_plus4_reg, if_id_pc_plus4_next;
  logic [31:0] redirect_addr;

  assign redirect_addr = {redirect_pc[31:2], 2'b00};

  // Memory request is suppressed while reset is held so no stale read lands afterwards.
  always_comb begin
    imem_rd_en = !rst && (redirect_valid || !stall);
    if (rst)
      imem_addr = RESET_PC;
    else if (redirect_valid)
      imem_addr = redirect_addr;
    else
      imem_addr = pc_reg;
  end

  always_comb begin
    pc_next             = pc_reg;
    inflight_next       = 1'b0;
    inflight_pc_next    = inflight_pc_reg;
    skid_valid_next     = skid_valid_reg;
    skid_instr_next     = skid_instr_reg;
    skid_pc_next        = skid_pc_reg;
    if_id_valid_next    = if_id_valid_reg;
    if_id_instr_next    = if_id_instr_reg;
    if_id_pc_plus4_next = if_id_pc_plus4_reg;

    if (redirect_valid) begin
      // Redirect kills the returning read and any skid contents.
      pc_next             = redirect_addr + 32'd4;
      inflight_next       = 1'b1;
      inflight_pc_next    = redirect_addr;
      skid_valid_next     = 1'b0;
      if_id_valid_next    = 1'b0;
      if_id_instr_next    = NOP_INSTR;
      if_id_pc_plus4_next = 32'd0;
    end else if (stall) begin
      if (inflight_reg) begin
        skid_valid_next = 1'b1;
        skid_instr_next = imem_rdata;
        skid_pc_next    = inflight_pc_reg + 32'd4;
      end
    end else begin
      pc_next          = pc_reg + 32'd4;
      inflight_next    = 1'b1;
      inflight_pc_next = pc_reg;
      if (skid_valid_reg) begin
        skid_valid_next     = 1'b0;
        if_id_valid_next    = 1'b1;
        if_id_instr_next    = skid_instr_reg;
        if_id_pc_plus4_next = skid_pc_reg;
      end else if (inflight_reg) begin
        if_id_valid_next    = 1'b1;
        if_id_instr_next    = imem_rdata;
        if_id_pc_plus4_next = inflight_pc_reg + 32'd4;
      end else begin
        // Nothing to deliver: insert a bubble rather than re-issue the old instruction.
        if_id_valid_next    = 1'b0;
        if_id_instr_next    = NOP_INSTR;
        if_id_pc_plus4_next = 32'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg             <= RESET_PC;
      inflight_reg       <= 1'b0;
      inflight_pc_reg    <= 32'd0;
      skid_valid_reg     <= 1'b0;
      skid_instr_reg     <= 32'd0;
      skid_pc_reg        <= 32'd0;
      if_id_valid_reg    <= 1'b0;
      if_id_instr_reg    <= NOP_INSTR;
      if_id_pc_plus4_reg <= 32'd0;
    end else begin
      pc_reg             <= pc_next;
      inflight_reg       <= inflight_next;
      inflight_pc_reg    <= inflight_pc_next;
      skid_valid_reg     <= skid_valid_next;
      skid_instr_reg     <= skid_instr_next;
      skid_pc_reg        <= skid_pc_next;
      if_id_valid_reg    <= if_id_valid_next;
      if_id_instr_reg    <= if_id_instr_next;
      if_id_pc_plus4_reg <= if_id_pc_plus4_next;
    end
  end

  assign if_id_valid    = if_id_valid_reg;
  assign if_id_instr    = if_id_instr_reg;
  assign if_id_pc_plus4 = if_id_pc_plus4_reg;

  // Control field is {opcode, funct}.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_ctrl
      assign if_id_ctrl[gi]     = if_id_instr_reg[gi];
      assign if_id_ctrl[gi + 6] = if_id_instr_reg[gi + 26];
    end
  endgenerate

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential run, stall/skid, redirect, redirect+stall,
// PC wraparound (second instance) and reset during a stall with the skid full.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_rd_en;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic [11:0] if_id_ctrl;

  logic        stall2, redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        imem_rd_en2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        if_id_valid2;
  logic [31:0] if_id_instr2, if_id_pc_plus42;
  logic [11:0] if_id_ctrl2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_ctrl(if_id_ctrl)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .stall(stall2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .imem_rd_en(imem_rd_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .if_id_valid(if_id_valid2), .if_id_instr(if_id_instr2),
    .if_id_pc_plus4(if_id_pc_plus42), .if_id_ctrl(if_id_ctrl2)
  );

  // Instruction memory contents: word at addr = addr ^ A5A5_0000, 1-cycle latency.
  always @(posedge clk) begin
    if (imem_rd_en)  imem_rdata  <= imem_addr  ^ 32'hA5A5_0000;
    if (imem_rd_en2) imem_rdata2 <= imem_addr2 ^ 32'hA5A5_0000;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Skid full while a read returns unstalled must never happen.
  always @(negedge clk) begin
    if (rst === 1'b0)
      chk("skid_inv", {31'd0, dut.inflight_reg & dut.skid_valid_reg & ~stall}, 32'd0);
  end

  task automatic drive(input logic st, input logic rv, input logic [31:0] rpc);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Check one cycle: fetch request (address only when a read is requested) and IF/ID.
  task automatic chk_cyc(input string tag, input logic rd, input logic [31:0] addr,
                         input logic v, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic [11:0] ctrl);
    $display("cyc %0d %s: rd_en=%0b addr=%h | valid=%0b instr=%h pc4=%h ctrl=%h",
             cyc, tag, imem_rd_en, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_ctrl);
    chk({tag, ".rd_en"}, {31'd0, imem_rd_en}, {31'd0, rd});
    if (rd) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc4"}, if_id_pc_plus4, pc4);
    chk({tag, ".ctrl"}, {20'd0, if_id_ctrl}, {20'd0, ctrl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = 32'd0;
    repeat (2) @(negedge clk);
    chk_cyc("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 12'h000);
    chk("reset.addr_rst", imem_addr, 32'h0);
    chk("reset2.addr", imem_addr2, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential run, also checks the wrapping instance alongside.
    drive(0, 0, 0); chk_cyc("seq1", 1, 32'h0, 0, 32'h0, 32'h0, 12'h000);
    chk("wrap.addr1", imem_addr2, 32'hFFFF_FFF8);
    chk("wrap.rd1", {31'd0, imem_rd_en2}, 32'd1);
    adv();
    drive(0, 0, 0); chk_cyc("seq2", 1, 32'h4, 0, 32'h0, 32'h0, 12'h000);
    chk("wrap.addr2", imem_addr2, 32'hFFFF_FFFC);
    adv();
    drive(0, 0, 0); chk_cyc("seq3", 1, 32'h8, 1, 32'hA5A5_0000, 32'h4, 12'hA40);
    chk("wrap.addr3", imem_addr2, 32'h0000_0000);
    chk("wrap.pc4_1", if_id_pc_plus42, 32'hFFFF_FFFC);
    chk("wrap.instr1", if_id_instr2, 32'h5A5A_FFF8);
    adv();

    // Stall three cycles with the fetch of 0x8 in flight.
    drive(1, 0, 0); chk_cyc("stall1", 0, 32'h0, 1, 32'hA5A5_0004, 32'h8, 12'hA44);
    chk("wrap.pc4_2", if_id_pc_plus42, 32'h0000_0000);
    chk("wrap.instr2", if_id_instr2, 32'h5A5A_FFFC);
    adv();
    drive(1, 0, 0); chk_cyc("stall2", 0, 32'h0, 1, 32'hA5A5_0004, 32'h8, 12'hA44);
    adv();
    drive(1, 0, 0); chk_cyc("stall3", 0, 32'h0, 1, 32'hA5A5_0004, 32'h8, 12'hA44);
    adv();
    drive(0, 0, 0); chk_cyc("release", 1, 32'hC, 1, 32'hA5A5_0004, 32'h8, 12'hA44);
    adv();
    drive(0, 0, 0); chk_cyc("drain", 1, 32'h10, 1, 32'hA5A5_0008, 32'hC, 12'hA48);
    adv();

    // Redirect to 0x103 while 0x10 is in flight.
    drive(0, 1, 32'h0000_0103); chk_cyc("redir", 1, 32'h100, 1, 32'hA5A5_000C, 32'h10, 12'hA4C);
    adv();
    drive(0, 0, 0); chk_cyc("bubble", 1, 32'h104, 0, 32'h0, 32'h0, 12'h000);
    adv();

    // Fill the skid, then redirect and stall together.
    drive(1, 0, 0); chk_cyc("tgt", 0, 32'h0, 1, 32'hA5A5_0100, 32'h104, 12'hA40);
    adv();
    drive(1, 1, 32'h0000_0200); chk_cyc("redir_stall", 1, 32'h200, 1, 32'hA5A5_0100, 32'h104, 12'hA40);
    adv();
    drive(0, 0, 0); chk_cyc("bubble2", 1, 32'h204, 0, 32'h0, 32'h0, 12'h000);
    adv();
    drive(0, 0, 0); chk_cyc("tgt2", 1, 32'h208, 1, 32'hA5A5_0200, 32'h204, 12'hA40);
    adv();

    // Reset in the middle of a stall with the skid holding 0x208.
    drive(1, 0, 0); chk_cyc("stall_a", 0, 32'h0, 1, 32'hA5A5_0204, 32'h208, 12'hA44);
    adv();
    drive(1, 0, 0); chk_cyc("stall_b", 0, 32'h0, 1, 32'hA5A5_0204, 32'h208, 12'hA44);
    rst = 1'b1;
    #1;
    chk_cyc("mid_rst", 0, 32'h0, 0, 32'h0, 32'h0, 12'h000);
    chk("mid_rst.addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    drive(0, 0, 0); chk_cyc("post1", 1, 32'h0, 0, 32'h0, 32'h0, 12'h000);
    adv();
    drive(0, 0, 0); chk_cyc("post2", 1, 32'h4, 0, 32'h0, 32'h0, 12'h000);
    adv();
    drive(0, 0, 0); chk_cyc("post3", 1, 32'h8, 1, 32'hA5A5_0000, 32'h4, 12'hA40);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
